rv32_mtimer: RTL and testbench



---
 rtl/rv32_mtimer.sv | 142 ++++++++++++++
 tb/tb_rv32_mtimer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp/msip) behind a single-cycle register bus.
// Bus: ack/rdata/err registered one cycle after req, no stall; time_irq registered off the compare.
module rv32_mtimer #(
   parameter int unsigned PRESCALE     = 1,
   parameter int unsigned PITO_HART_ID = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] wdata_i,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        time_irq_o,
   output logic        ipi_o
);

   generate
      if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
         $error("rv32_mtimer hart %0d: PRESCALE %0d out of range", PITO_HART_ID, PRESCALE);
      end else begin : g_banner
         $info("rv32_mtimer hart %0d: PRESCALE %0d", PITO_HART_ID, PRESCALE);
      end
   endgenerate

   localparam logic [15:0] PCNT_LAST = 16'(PRESCALE - 1);

   localparam logic [2:0] A_MSIP    = 3'd0;
   localparam logic [2:0] A_CMP_LO  = 3'd1;
   localparam logic [2:0] A_CMP_HI  = 3'd2;
   localparam logic [2:0] A_TIME_LO = 3'd3;
   localparam logic [2:0] A_TIME_HI = 3'd4;

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic [15:0] pcnt_q, pcnt_d;
   logic        msip_q, msip_d;
   logic [31:0] snap_q, snap_d;
   logic        snap_vld_q, snap_vld_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic        irq_q;
   logic        tick;
   logic        unused_addr;

   assign unused_addr = ^addr_i[1:0];
   assign tick        = enable_i && (pcnt_q == PCNT_LAST);

   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      pcnt_d     = pcnt_q;
      msip_d     = msip_q;
      snap_d     = snap_q;
      snap_vld_d = snap_vld_q;
      ack_d      = req_i;
      err_d      = 1'b0;
      rdata_d    = 32'd0;

      if (enable_i) begin
         pcnt_d = tick ? 16'd0 : pcnt_q + 16'd1;
      end
      if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end

      if (req_i) begin
         snap_vld_d = 1'b0;
         case (addr_i[4:2])
            A_MSIP: begin
               if (we_i) msip_d = wdata_i[0];
               else      rdata_d = {31'd0, msip_q};
            end
            A_CMP_LO: begin
               if (we_i) mtimecmp_d[31:0] = wdata_i;
               else      rdata_d = mtimecmp_q[31:0];
            end
            A_CMP_HI: begin
               if (we_i) mtimecmp_d[63:32] = wdata_i;
               else      rdata_d = mtimecmp_q[63:32];
            end
            // Software writes override the tick: the other half keeps its pre-edge value.
            A_TIME_LO: begin
               if (we_i) begin
                  mtime_d = {mtime_q[63:32], wdata_i};
                  pcnt_d  = 16'd0;
               end else begin
                  rdata_d    = mtime_q[31:0];
                  snap_d     = mtime_q[63:32];
                  snap_vld_d = 1'b1;
               end
            end
            A_TIME_HI: begin
               if (we_i) begin
                  mtime_d = {wdata_i, mtime_q[31:0]};
                  pcnt_d  = 16'd0;
               end else begin
                  rdata_d = snap_vld_q ? snap_q : mtime_q[63:32];
               end
            end
            default: err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= '1;
         pcnt_q     <= 16'd0;
         msip_q     <= 1'b0;
         snap_q     <= 32'd0;
         snap_vld_q <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         pcnt_q     <= pcnt_d;
         msip_q     <= msip_d;
         snap_q     <= snap_d;
         snap_vld_q <= snap_vld_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         irq_q      <= (mtime_q >= mtimecmp_q);
      end
   end

   assign ack_o      = ack_q;
   assign err_o      = err_q;
   assign rdata_o    = rdata_q;
   assign time_irq_o = irq_q;
   assign ipi_o      = msip_q;

endmodule

// File: tb/tb_rv32_mtimer.sv
// Bench for rv32_mtimer: two instances (PRESCALE 4 and 1) against an elapsed-cycle timer model.
module tb_rv32_mtimer;

   localparam logic [4:0] A_MSIP = 5'h00, A_CLO = 5'h04, A_CHI = 5'h08, A_TLO = 5'h0C, A_THI = 5'h10;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  en;
   int          sel;
   logic        req_r, we_r;
   logic [4:0]  addr_r;
   logic [31:0] wdata_r;
   logic        req_w [2];
   logic        ack [2], err [2], irq [2], ipi [2];
   logic [31:0] rdata [2];

   always #5 clk = ~clk;

   assign req_w[0] = req_r && (sel == 0);
   assign req_w[1] = req_r && (sel == 1);

   rv32_mtimer #(.PRESCALE(4), .PITO_HART_ID(0)) u_dut4 (
      .clk(clk), .rst(rst), .enable_i(en[0]), .req_i(req_w[0]), .we_i(we_r), .addr_i(addr_r),
      .wdata_i(wdata_r), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]),
      .time_irq_o(irq[0]), .ipi_o(ipi[0]));

   rv32_mtimer #(.PRESCALE(1), .PITO_HART_ID(1)) u_dut1 (
      .clk(clk), .rst(rst), .enable_i(en[1]), .req_i(req_w[1]), .we_i(we_r), .addr_i(addr_r),
      .wdata_i(wdata_r), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]),
      .time_irq_o(irq[1]), .ipi_o(ipi[1]));

   int total = 0;
   int bad   = 0;

   // Model: mtime = value last written + (enabled cycles since then) / PRESCALE.
   int unsigned     presc [2] = '{4, 1};
   logic [63:0]     m_base [2], m_cmp [2];
   longint unsigned m_ecnt [2];
   logic            m_msip [2], m_snapv [2];
   logic [31:0]     m_snap [2];
   logic            e_irq [2], e_ipi [2];
   bit              mon_on = 1'b0;

   logic        r_ack, r_err, x_err;
   logic [31:0] r_rd, x_rd;

   function automatic logic [63:0] model_time(int j);
      return m_base[j] + 64'(m_ecnt[j] / presc[j]);
   endfunction

   task automatic reset_model();
      for (int j = 0; j < 2; j++) begin
         m_base[j] = '0; m_ecnt[j] = 0; m_cmp[j] = '1; m_msip[j] = 1'b0;
         m_snapv[j] = 1'b0; m_snap[j] = '0; e_irq[j] = 1'b0; e_ipi[j] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         for (int j = 0; j < 2; j++) begin
            total++;
            if (irq[j] !== e_irq[j]) begin
               bad++;
               $display("FAIL irq_track[%0d] t=%0t got=%b want=%b", j, $time, irq[j], e_irq[j]);
            end
            total++;
            if (ipi[j] !== e_ipi[j]) begin
               bad++;
               $display("FAIL ipi_track[%0d] t=%0t got=%b want=%b", j, $time, ipi[j], e_ipi[j]);
            end
         end
      end
   end

   // One clock with an optional bus access on instance k; model advanced for both instances.
   task automatic step(input int k, input bit rq, input bit wr, input logic [4:0] ad,
                       input logic [31:0] wd);
      logic [63:0] cur;
      logic [2:0]  idx;
      bit          wrote;
      logic        n_irq [2];
      sel = k; req_r = rq; we_r = wr; addr_r = ad; wdata_r = wd;
      x_rd = '0; x_err = 1'b0; idx = ad[4:2];
      for (int j = 0; j < 2; j++) begin
         cur = model_time(j);
         n_irq[j] = (cur >= m_cmp[j]);
         wrote = 1'b0;
         if (rq && j == k) begin
            if (idx > 3'd4) begin
               x_err = 1'b1;
            end else if (wr) begin
               case (idx)
                  3'd0: m_msip[j] = wd[0];
                  3'd1: m_cmp[j][31:0] = wd;
                  3'd2: m_cmp[j][63:32] = wd;
                  3'd3: begin m_base[j] = {cur[63:32], wd}; m_ecnt[j] = 0; wrote = 1'b1; end
                  default: begin m_base[j] = {wd, cur[31:0]}; m_ecnt[j] = 0; wrote = 1'b1; end
               endcase
            end else begin
               case (idx)
                  3'd0: x_rd = {31'd0, m_msip[j]};
                  3'd1: x_rd = m_cmp[j][31:0];
                  3'd2: x_rd = m_cmp[j][63:32];
                  3'd3: x_rd = cur[31:0];
                  default: x_rd = m_snapv[j] ? m_snap[j] : cur[63:32];
               endcase
            end
            if (!wr && idx == 3'd3) begin
               m_snapv[j] = 1'b1; m_snap[j] = cur[63:32];
            end else begin
               m_snapv[j] = 1'b0;
            end
         end
         if (!wrote && en[j]) m_ecnt[j]++;
      end
      @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         e_irq[j] = n_irq[j];
         e_ipi[j] = m_msip[j];
      end
      r_ack = ack[k]; r_err = err[k]; r_rd = rdata[k];
      req_r = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 2'b00; req_r = 1'b0; we_r = 1'b0; addr_r = '0; wdata_r = '0; sel = 0;
      reset_model();
      repeat (2) @(posedge clk);
      #1;
      for (int j = 0; j < 2; j++) begin
         total++;
         if (ack[j] !== 1'b0 || err[j] !== 1'b0 || rdata[j] !== 32'd0 || irq[j] !== 1'b0 || ipi[j] !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs[%0d] got ack=%b err=%b rd=%h irq=%b ipi=%b want all 0",
                     j, ack[j], err[j], rdata[j], irq[j], ipi[j]);
         end
      end
      rst = 1'b0;
      step(0, 1'b0, 1'b0, A_MSIP, '0);
      mon_on = 1'b1;
      total++;
      if (r_ack !== 1'b0) begin bad++; $display("FAIL reset_idle_ack got=%b want=0", r_ack); end
      for (int j = 0; j < 2; j++) begin
         step(j, 1'b1, 1'b0, A_CLO, '0);
         total++;
         if (r_ack !== 1'b1 || r_rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL reset_cmp_lo[%0d] got ack=%b rd=%h want ack=1 rd=ffffffff", j, r_ack, r_rd);
         end
         step(j, 1'b1, 1'b0, A_CHI, '0);
         total++;
         if (r_ack !== 1'b1 || r_rd !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL reset_cmp_hi[%0d] got ack=%b rd=%h want ack=1 rd=ffffffff", j, r_ack, r_rd);
         end
      end
      step(1, 1'b0, 1'b0, A_MSIP, '0);
      total++;
      if (r_ack !== 1'b0) begin bad++; $display("FAIL ack_pulse got=%b want=0", r_ack); end
   endtask

   task automatic test_prescale();
      en[0] = 1'b0;
      step(0, 1'b1, 1'b1, A_THI, 32'd0);
      step(0, 1'b1, 1'b1, A_TLO, 32'd0);
      en[0] = 1'b1;
      repeat (40) step(0, 1'b0, 1'b0, A_MSIP, '0);
      en[0] = 1'b0;
      step(0, 1'b1, 1'b0, A_TLO, '0);
      total++;
      if (r_rd !== 32'd10) begin bad++; $display("FAIL prescale_count got=%0d want=10", r_rd); end
      repeat (20) step(0, 1'b0, 1'b0, A_MSIP, '0);
      step(0, 1'b1, 1'b0, A_TLO, '0);
      total++;
      if (r_rd !== 32'd10) begin bad++; $display("FAIL prescale_frozen got=%0d want=10", r_rd); end
   endtask

   task automatic test_time_irq();
      int first;
      en[1] = 1'b0;
      step(1, 1'b1, 1'b1, A_CHI, 32'd0);
      step(1, 1'b1, 1'b1, A_CLO, 32'd20);
      step(1, 1'b1, 1'b1, A_THI, 32'd0);
      en[1] = 1'b1;
      step(1, 1'b1, 1'b1, A_TLO, 32'd0);
      first = -1;
      for (int i = 1; i <= 30; i++) begin
         step(1, 1'b0, 1'b0, A_MSIP, '0);
         if (first < 0 && irq[1] === 1'b1) first = i;
      end
      total++;
      if (first != 21) begin bad++; $display("FAIL irq_rise_cycle got=%0d want=21", first); end
      step(1, 1'b1, 1'b1, A_CLO, 32'hFFFF_FFFF);
      total++;
      if (irq[1] !== 1'b1) begin bad++; $display("FAIL irq_hold_after_write got=%b want=1", irq[1]); end
      step(1, 1'b0, 1'b0, A_MSIP, '0);
      total++;
      if (irq[1] !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b want=0", irq[1]); end
      en[1] = 1'b0;
   endtask

   task automatic test_wrap();
      en[1] = 1'b0;
      step(1, 1'b1, 1'b1, A_THI, 32'd0);
      step(1, 1'b1, 1'b1, A_TLO, 32'hFFFF_FFFF);
      en[1] = 1'b1;
      step(1, 1'b0, 1'b0, A_MSIP, '0);
      en[1] = 1'b0;
      step(1, 1'b1, 1'b0, A_TLO, '0);
      total++;
      if (r_rd !== 32'd0) begin bad++; $display("FAIL wrap_lo got=%h want=00000000", r_rd); end
      step(1, 1'b1, 1'b0, A_THI, '0);
      total++;
      if (r_rd !== 32'd1) begin bad++; $display("FAIL wrap_hi got=%h want=00000001", r_rd); end
      step(1, 1'b1, 1'b1, A_THI, 32'd5);
      step(1, 1'b1, 1'b1, A_TLO, 32'hFFFF_FFFF);
      en[1] = 1'b1;
      step(1, 1'b1, 1'b0, A_TLO, '0);
      en[1] = 1'b0;
      total++;
      if (r_rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL carry_lo got=%h want=ffffffff", r_rd); end
      step(1, 1'b1, 1'b0, A_THI, '0);
      total++;
      if (r_rd !== 32'd5) begin bad++; $display("FAIL carry_snap_hi got=%h want=00000005", r_rd); end
      step(1, 1'b1, 1'b0, A_THI, '0);
      total++;
      if (r_rd !== 32'd6) begin bad++; $display("FAIL carry_live_hi got=%h want=00000006", r_rd); end
   endtask

   task automatic test_msip();
      step(0, 1'b1, 1'b1, A_MSIP, 32'hFFFF_FFFF);
      total++;
      if (ipi[0] !== 1'b1) begin bad++; $display("FAIL msip_set got=%b want=1", ipi[0]); end
      step(0, 1'b1, 1'b0, A_MSIP, '0);
      total++;
      if (r_rd !== 32'd1) begin bad++; $display("FAIL msip_read got=%h want=00000001", r_rd); end
      step(0, 1'b1, 1'b1, A_MSIP, 32'd0);
      total++;
      if (ipi[0] !== 1'b0) begin bad++; $display("FAIL msip_clear got=%b want=0", ipi[0]); end
   endtask

   task automatic test_unmapped();
      logic [4:0] ua [3] = '{5'h14, 5'h18, 5'h1C};
      logic [4:0] ma [5] = '{A_MSIP, A_CLO, A_CHI, A_TLO, A_THI};
      en[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(0, 1'b1, 1'(i & 1), ua[i], $urandom);
         total++;
         if (r_ack !== 1'b1 || r_err !== 1'b1 || r_rd !== 32'd0) begin
            bad++; $display("FAIL unmapped_%h got ack=%b err=%b rd=%h want 1 1 0", ua[i], r_ack, r_err, r_rd);
         end
      end
      step(0, 1'b1, 1'b1, 5'h18, 32'hDEAD_BEEF);
      for (int i = 0; i < 5; i++) begin
         step(0, 1'b1, 1'b0, ma[i], '0);
         total++;
         if (r_err !== 1'b0 || r_rd !== x_rd) begin
            bad++; $display("FAIL unmapped_nochange_%h got err=%b rd=%h want err=0 rd=%h", ma[i], r_err, r_rd, x_rd);
         end
      end
   endtask

   task automatic test_tick_collision();
      logic [31:0] v;
      v = $urandom;
      en[1] = 1'b1;
      step(1, 1'b1, 1'b1, A_TLO, v);
      step(1, 1'b1, 1'b0, A_TLO, '0);
      total++;
      if (r_rd !== v) begin bad++; $display("FAIL tick_collision got=%h want=%h", r_rd, v); end
      en[1] = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [4:0] ma [5] = '{A_MSIP, A_CLO, A_CHI, A_TLO, A_THI};
      en[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(0, 1'b1, 1'b0, ma[i], '0);
         total++;
         if (r_ack !== 1'b1 || r_rd !== x_rd) begin
            bad++; $display("FAIL b2b_%h got ack=%b rd=%h want ack=1 rd=%h", ma[i], r_ack, r_rd, x_rd);
         end
      end
      step(0, 1'b0, 1'b0, A_MSIP, '0);
      total++;
      if (r_ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_drop got=%b want=0", r_ack); end
   endtask

   task automatic test_random();
      int  k;
      bit  rq, wr;
      logic [4:0]  ad;
      logic [31:0] wd;
      for (int i = 0; i < 400; i++) begin
         en = 2'($urandom_range(0, 3));
         k  = int'($urandom_range(0, 1));
         rq = ($urandom_range(0, 3) != 0);
         wr = 1'($urandom_range(0, 1));
         ad = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 3))
            0:       wd = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            1:       wd = 32'($urandom_range(0, 40));
            default: wd = $urandom;
         endcase
         step(k, rq, wr, ad, wd);
         total++;
         if (r_ack !== 1'(rq) || r_err !== x_err || r_rd !== x_rd) begin
            bad++;
            $display("FAIL random_%0d inst=%0d addr=%h we=%b got ack=%b err=%b rd=%h want ack=%b err=%b rd=%h",
                     i, k, ad, wr, r_ack, r_err, r_rd, rq, x_err, x_rd);
         end
      end
      en = 2'b00;
   endtask

   task automatic test_reset_midop();
      step(0, 1'b1, 1'b1, A_MSIP, 32'd1);
      mon_on = 1'b0;
      sel = 0; req_r = 1'b1; we_r = 1'b1; addr_r = A_CHI; wdata_r = 32'd0;
      #2 rst = 1'b1;
      #1;
      total++;
      if (ipi[0] !== 1'b0 || irq[0] !== 1'b0 || irq[1] !== 1'b0 || ack[0] !== 1'b0) begin
         bad++; $display("FAIL midop_async got ipi=%b irq0=%b irq1=%b ack=%b want 0", ipi[0], irq[0], irq[1], ack[0]);
      end
      @(posedge clk);
      #1;
      total++;
      if (ack[0] !== 1'b0) begin bad++; $display("FAIL midop_no_ack got=%b want=0", ack[0]); end
      req_r = 1'b0;
      rst = 1'b0;
      en = 2'b00;
      reset_model();
      step(0, 1'b1, 1'b0, A_CHI, '0);
      mon_on = 1'b1;
      total++;
      if (r_rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL midop_cmp_hi got=%h want=ffffffff", r_rd); end
      step(0, 1'b1, 1'b0, A_MSIP, '0);
      total++;
      if (r_rd !== 32'd0) begin bad++; $display("FAIL midop_msip got=%h want=00000000", r_rd); end
   endtask

   initial begin
      test_reset();
      test_prescale();
      test_time_irq();
      test_wrap();
      test_msip();
      test_unmapped();
      test_tick_collision();
      test_back_to_back();
      test_random();
      test_reset_midop();
      mon_on = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
